aes_round_iter: RTL and testbench
=================================

# aes_round_iter

Iterative AES-128 round engine that owns the 128-bit state register and drives the shared sub-bytes stage once per clock. It accepts one block over a valid/ready handshake, applies the initial AddRoundKey, runs 10 rounds in either direction, and presents the result over a second valid/ready handshake. Round keys come from an external key store that the block indexes through `Round_idx`.

## Interface
- Parameters: none. Block width is `AES_BLOCK_SIZE` (128), fixed at AES-128 with 10 rounds.
- Clk  in  1  single clock; all state updates on the rising edge.
- Nrst  in  1  asynchronous, active-low reset.
- Encrypt  in  1  1 = encrypt, 0 = decrypt; sampled only on the accept edge.
- Input_valid  in  1  upstream has a block.
- Input_ready  out  1  block can be accepted.
- Input_block  in  128  plaintext or ciphertext; [127:120] is state byte s(0,0), column-major.
- Round_key  in  128  key selected by `Round_idx`; combinational lookup, valid in the same cycle.
- Round_idx  out  4  round-key index, 0..10.
- Output_valid  out  1  result held.
- Output_ready  in  1  downstream consumes the result.
- Output_block  out  128  result, same byte order as `Input_block`.
- Clock and reset are fixed as above: one clock, asynchronous active-low reset.

## Operation
- FSM states are IDLE, ROUND and DONE.
- **Registers:** state[127:0], rnd[3:0] (round counter, 1..10), dir (latched `Encrypt`).
- **IDLE:**
  - `Input_ready` = 1.
  - `Round_idx` = `Encrypt` ? 0 : 10.
  - On `Input_valid`: state <= `Input_block` ^ `Round_key`; dir <= `Encrypt`; rnd <= 1; go to ROUND.
- **ROUND, encrypt (dir = 1):**
  - `Round_idx` = rnd.
  - state <= MixColumns(ShiftRows(SubBytes(state))) ^ `Round_key`.
  - When rnd = 10, MixColumns is bypassed.
- **ROUND, decrypt (dir = 0):**
  - `Round_idx` = 10 − rnd.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ `Round_key`).
  - When rnd = 10 (`Round_idx` = 0), InvMixColumns is bypassed.
- **Sub-bytes stage:** a single shared instance with `Encrypt` = dir, fed by state (encrypt) or by InvShiftRows(state) (decrypt). ShiftRows, MixColumns and their inverses are combinational inside this block.
- **Round counter:** rnd increments each ROUND cycle. At rnd = 10, after the update, go to DONE.
- **DONE:**
  - `Output_valid` = 1 and `Output_block` = state, both held stable until `Output_ready`.
  - On `Output_ready`, go to IDLE.
  - `Input_ready` = 0.
- **Mid-operation changes:** `Encrypt` and `Input_block` changes after accept are ignored. `Input_valid` is ignored outside IDLE.

## Timing
- **Reset (Nrst = 0, asynchronous):**
  - FSM → IDLE; state, rnd and dir → 0.
  - `Output_valid` = 0 and `Output_block` = 0.
  - `Input_ready` = 1 and `Round_idx` = `Encrypt` ? 0 : 10.
- **Reset mid-operation:** the in-flight block is discarded and no `Output_valid` is produced.
- **Latency:** the accept edge is T0. Rounds 1..10 update on edges T1..T10. `Output_valid` is high from just after T10.
- **Throughput:** minimum 12 cycles per block (accept, 10 rounds, one DONE cycle with `Output_ready` = 1).
- **Input handshake:** the transfer occurs on an edge with `Input_valid` & `Input_ready`. `Input_ready` is a function of FSM state only; no combinational path from `Input_valid`.
- **Output handshake:** the transfer occurs on an edge with `Output_valid` & `Output_ready`. Back-pressure holds DONE indefinitely, with output stable and `Input_ready` = 0.
- **Output_ready early:** `Output_ready` asserted before `Output_valid` has no effect.
- **Next accept after output transfer:** the first possible accept is the edge after the output-transfer edge. `Input_valid` held through DONE is accepted then.
- **Round_idx:** changes only on clock edges or when `Encrypt` changes in IDLE. It sequences 0,1..10 for encrypt and 10,9..0 for decrypt.

## Test plan
- **Encrypt, FIPS-197 C.1:** key 000102030405060708090a0b0c0d0e0f; bench supplies round keys by `Round_idx`; input 00112233445566778899aabbccddeeff, `Encrypt` = 1 -> `Output_block` 69c4e0d86a7b0430d8cdb78070b4c55a, `Output_valid` rising 10 cycles after accept, `Round_idx` trace 0,1..10.
- **Decrypt, same key:** input 69c4e0d86a7b0430d8cdb78070b4c55a, `Encrypt` = 0 -> 00112233445566778899aabbccddeeff, `Round_idx` trace 10,9..0.
- **Encrypt, FIPS-197 Appendix B:** key 2b7e151628aed2a6abf7158809cf4f3c, input 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- **Back-pressure:** hold `Output_ready` = 0 for 20 cycles in DONE -> output stable, `Input_ready` = 0, pending `Input_valid` not accepted. Release -> next block accepted on the following edge.
- **Back-to-back mixed blocks:** `Input_valid` held with alternating encrypt/decrypt blocks and `Encrypt` toggled mid-operation -> each result correct per its accept-time `Encrypt`; exactly 12 cycles between accepts.
- **Reset mid-round:** pulse Nrst low at round 5 -> immediately `Output_valid` = 0, `Output_block` = 0, `Input_ready` = 1. The next block after release completes correctly.

Source files
------------

// File: rtl/aes_round_iter_if.sv
// Block-level handshake bundle for aes_round_iter: input block, round-key lookup and result.
// The master side is the upstream/key-store owner; the slave side is the round engine.
interface aes_round_iter_if;
  localparam int unsigned AES_BLOCK_SIZE = 128;

  logic                      Encrypt;
  logic                      Input_valid;
  logic                      Input_ready;
  logic [AES_BLOCK_SIZE-1:0] Input_block;
  logic [AES_BLOCK_SIZE-1:0] Round_key;
  logic [3:0]                Round_idx;
  logic                      Output_valid;
  logic                      Output_ready;
  logic [AES_BLOCK_SIZE-1:0] Output_block;

  modport master (
    output Encrypt, Input_valid, Input_block, Round_key, Output_ready,
    input  Input_ready, Round_idx, Output_valid, Output_block
  );

  modport slave (
    input  Encrypt, Input_valid, Input_block, Round_key, Output_ready,
    output Input_ready, Round_idx, Output_valid, Output_block
  );
endinterface

// File: rtl/aes_round_iter.sv
// Iterative AES-128 round engine: one round per clock over a 128-bit state register,
// encrypt or decrypt, with round keys fetched from an external store via Round_idx.
module aes_round_iter (
  input  logic            Clk,
  input  logic            Nrst,
  aes_round_iter_if.slave bus
);
  localparam int unsigned AES_BLOCK_SIZE = 128;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

  fsm_t                      fsm, fsm_nxt;
  logic [AES_BLOCK_SIZE-1:0] state;
  logic [3:0]                rnd;
  logic                      dir;
  logic                      load, step, last;
  logic [AES_BLOCK_SIZE-1:0] sub_in, sub_out, sr_out, mc_in, mc_out, round_out;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r, p;
    logic [7:0] e;
    r = 8'h01;
    p = x;
    e = 8'hfe;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  // Forward and inverse S-box share one field inversion; only the affine step moves.
  function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic enc);
    logic [7:0] pre, inv;
    pre = enc ? x : (rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
    inv = gf_inv(pre);
    if (enc)
      return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    return inv;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic enc);
    logic [127:0] o;
    o = '0;
    for (int unsigned k = 0; k < 16; k++)
      o[8*(15-k) +: 8] = sub_byte(s[8*(15-k) +: 8], enc);
    return o;
  endfunction

  // Byte k = 4*col + row, with byte 0 in the top bits.
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int unsigned  src;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++) begin
        src = inv ? (c + 4 - r) % 4 : (c + r) % 4;
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*src+r)) +: 8];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [7:0]   m [4];
    logic [7:0]   a [4];
    logic [7:0]   acc;
    logic [127:0] o;
    if (inv) begin
      m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
    end else begin
      m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
    end
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++)
        a[r] = s[8*(15-(4*c+r)) +: 8];
      for (int unsigned r = 0; r < 4; r++) begin
        acc = '0;
        for (int unsigned j = 0; j < 4; j++)
          acc = acc ^ gmul(m[j], a[(r+j)%4]);
        o[8*(15-(4*c+r)) +: 8] = acc;
      end
    end
    return o;
  endfunction

  assign last = (rnd == 4'd10);

  // Decrypt applies InvShiftRows before the shared sub-bytes stage and the key before
  // InvMixColumns, so one mix-columns instance serves both directions.
  assign sub_in  = dir ? state : shift_rows(state, 1'b1);
  assign sub_out = sub_bytes(sub_in, dir);
  assign sr_out  = shift_rows(sub_out, 1'b0);
  assign mc_in   = dir ? sr_out : (sub_out ^ bus.Round_key);
  assign mc_out  = mix_columns(mc_in, !dir);

  always_comb begin
    round_out = '0;
    if (dir) round_out = (last ? sr_out : mc_out) ^ bus.Round_key;
    else     round_out = last ? mc_in : mc_out;
  end

  always_ff @(posedge Clk or negedge Nrst) begin
    if (!Nrst) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt          = fsm;
    load             = 1'b0;
    step             = 1'b0;
    bus.Input_ready  = 1'b0;
    bus.Output_valid = 1'b0;
    case (fsm)
      IDLE: begin
        bus.Input_ready = 1'b1;
        if (bus.Input_valid) begin
          load    = 1'b1;
          fsm_nxt = ROUND;
        end
      end
      ROUND: begin
        step = 1'b1;
        if (last) fsm_nxt = DONE;
      end
      DONE: begin
        bus.Output_valid = 1'b1;
        if (bus.Output_ready) fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Nrst) begin
    if (!Nrst) begin
      state <= '0;
      rnd   <= '0;
      dir   <= 1'b0;
    end else if (load) begin
      state <= bus.Input_block ^ bus.Round_key;
      dir   <= bus.Encrypt;
      rnd   <= 4'd1;
    end else if (step) begin
      state <= round_out;
      if (!last) rnd <= rnd + 4'd1;
    end
  end

  // rnd parks at 10 in DONE, so the index stays on the last key used.
  assign bus.Round_idx    = (fsm == IDLE) ? (bus.Encrypt ? 4'd0 : 4'd10)
                                          : (dir ? rnd : 4'd10 - rnd);
  assign bus.Output_block = state;
endmodule

// File: tb/tb_aes_round_iter.sv
// Bench for aes_round_iter: FIPS-197 vectors, random blocks against a byte-level AES model,
// back-pressure, back-to-back mixed-direction traffic and reset mid-round.
module tb_aes_round_iter;
  logic clk  = 1'b0;
  logic nrst = 1'b0;

  aes_round_iter_if b();
  aes_round_iter dut (.Clk(clk), .Nrst(nrst), .bus(b));

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] blk;
    logic         enc;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   sbox [256];
  logic [127:0] rk [11];
  logic [127:0] q [$];

  always_comb b.Round_key = (b.Round_idx <= 4'd10) ? rk[b.Round_idx] : '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // S-box from walking the multiplicative group: p steps by 3, q by 1/3 = p^-1.
  task automatic gen_sbox();
    logic [7:0] p, qq, x;
    p  = 8'h01;
    qq = 8'h01;
    do begin
      p  = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      qq = qq ^ {qq[6:0], 1'b0};
      qq = qq ^ {qq[5:0], 2'b0};
      qq = qq ^ {qq[3:0], 4'b0};
      if (qq[7]) qq = qq ^ 8'h09;
      x = qq ^ {qq[6:0], qq[7]} ^ {qq[5:0], qq[7:6]} ^ {qq[4:0], qq[7:5]} ^ {qq[3:0], qq[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int k = 0; k < 16; k++) s[k] = pt[8*(15-k) +: 8] ^ rk[0][8*(15-k) +: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int k = 0; k < 16; k++) t[k] = sbox[s[k]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (rd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      for (int k = 0; k < 16; k++) s[k] = s[k] ^ rk[rd][8*(15-k) +: 8];
    end
    for (int k = 0; k < 16; k++) o[8*(15-k) +: 8] = s[k];
    return o;
  endfunction

  // One full transaction starting from IDLE, with Round_idx trace and latency checks.
  task automatic run_block(input logic [127:0] key, input logic [127:0] blk, input logic enc,
                           input logic [127:0] exp, input string tag);
    set_key(key);
    @(negedge clk);
    b.Input_block = blk; b.Encrypt = enc; b.Input_valid = 1'b1; b.Output_ready = 1'b0;
    #1;
    check({tag, "_in_ready"}, 128'(b.Input_ready), 128'(1));
    check({tag, "_idx_idle"}, 128'(b.Round_idx), enc ? 128'(0) : 128'(10));
    @(negedge clk);
    b.Input_valid = 1'b0; b.Encrypt = ~enc; b.Input_block = rand128();
    for (int r = 1; r <= 10; r++) begin
      #1;
      check({tag, "_idx"}, 128'(b.Round_idx), enc ? 128'(r) : 128'(10 - r));
      check({tag, "_early_valid"}, 128'(b.Output_valid), 128'(0));
      @(negedge clk);
    end
    #1;
    check({tag, "_valid"}, 128'(b.Output_valid), 128'(1));
    check({tag, "_out"}, b.Output_block, exp);
    check({tag, "_busy_ready"}, 128'(b.Input_ready), 128'(0));
    b.Output_ready = 1'b1;
    @(negedge clk);
    #1;
    check({tag, "_drained"}, 128'(b.Output_valid), 128'(0));
    b.Output_ready = 1'b0;
  endtask

  initial begin
    vec_t         vecs [4];
    logic [127:0] key, pt, ct;
    logic         enc_b;
    int           blk_i, last_acc;

    gen_sbox();
    b.Encrypt = 1'b0; b.Input_valid = 1'b0; b.Input_block = '0; b.Output_ready = 1'b0;
    #12;
    check("rst_out_valid", 128'(b.Output_valid), 128'(0));
    check("rst_out_block", b.Output_block, 128'(0));
    check("rst_in_ready", 128'(b.Input_ready), 128'(1));
    check("rst_idx_dec", 128'(b.Round_idx), 128'(10));
    b.Encrypt = 1'b1;
    #1;
    check("rst_idx_enc", 128'(b.Round_idx), 128'(0));
    @(negedge clk);
    nrst = 1'b1;

    vecs[0] = '{K1, PT1, 1'b1, CT1};
    vecs[1] = '{K1, CT1, 1'b0, PT1};
    vecs[2] = '{K2, PT2, 1'b1, CT2};
    vecs[3] = '{K2, CT2, 1'b0, PT2};
    for (int i = 0; i < 4; i++)
      run_block(vecs[i].key, vecs[i].blk, vecs[i].enc, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      key = rand128();
      pt  = rand128();
      set_key(key);
      ct = model_enc(pt);
      run_block(key, pt, 1'b1, ct, $sformatf("rnd_enc%0d", i));
      run_block(key, ct, 1'b0, pt, $sformatf("rnd_dec%0d", i));
    end

    // Back-pressure: result held 20 cycles while the next block waits with valid high.
    set_key(K1);
    @(negedge clk);
    b.Input_block = PT1; b.Encrypt = 1'b1; b.Input_valid = 1'b1; b.Output_ready = 1'b0;
    @(negedge clk);
    b.Input_block = CT1; b.Encrypt = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      #1;
      check("bp_valid", 128'(b.Output_valid), 128'(1));
      check("bp_out", b.Output_block, CT1);
      check("bp_in_ready", 128'(b.Input_ready), 128'(0));
      @(negedge clk);
    end
    b.Output_ready = 1'b1;
    @(negedge clk);
    #1;
    check("bp_release_ready", 128'(b.Input_ready), 128'(1));
    b.Output_ready = 1'b0;
    @(negedge clk);
    #1;
    check("bp_next_idx", 128'(b.Round_idx), 128'(9));
    b.Input_valid = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("bp_next_valid", 128'(b.Output_valid), 128'(1));
    check("bp_next_out", b.Output_block, PT1);
    b.Output_ready = 1'b1;
    @(negedge clk);
    b.Output_ready = 1'b0;

    // Back-to-back: valid and ready held, direction alternating, Encrypt scrambled mid-flight.
    set_key(K1);
    @(negedge clk);
    b.Output_ready = 1'b1; b.Input_valid = 1'b1;
    blk_i = 0; last_acc = -100;
    for (int cyc = 0; cyc < 70; cyc++) begin
      #1;
      if (b.Output_valid) begin
        check("b2b_latency", 128'(cyc - last_acc), 128'(11));
        check("b2b_inflight", 128'(q.size()), 128'(1));
        if (q.size() > 0) check("b2b_out", b.Output_block, q.pop_front());
      end
      if (b.Input_ready) begin
        if (blk_i < 5) begin
          if (blk_i > 0) check("b2b_gap", 128'(cyc - last_acc), 128'(12));
          last_acc = cyc;
          enc_b = (blk_i % 2 == 0);
          pt = rand128();
          ct = model_enc(pt);
          b.Encrypt = enc_b;
          b.Input_block = enc_b ? pt : ct;
          q.push_back(enc_b ? ct : pt);
          blk_i++;
        end else begin
          b.Input_valid = 1'b0;
        end
      end else begin
        b.Encrypt = 1'($urandom);
        b.Input_block = rand128();
      end
      @(negedge clk);
    end
    check("b2b_accepts", 128'(blk_i), 128'(5));
    check("b2b_drained", 128'(q.size()), 128'(0));
    b.Output_ready = 1'b0; b.Input_valid = 1'b0;

    // Reset pulse during round 5 drops the block; the engine then works normally.
    set_key(K1);
    @(negedge clk);
    b.Input_block = PT1; b.Encrypt = 1'b1; b.Input_valid = 1'b1;
    @(negedge clk);
    b.Input_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("rmid_idx", 128'(b.Round_idx), 128'(5));
    #1;
    nrst = 1'b0;
    #1;
    check("rmid_valid", 128'(b.Output_valid), 128'(0));
    check("rmid_block", b.Output_block, 128'(0));
    check("rmid_in_ready", 128'(b.Input_ready), 128'(1));
    check("rmid_idx_idle", 128'(b.Round_idx), 128'(0));
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      #1;
      check("rmid_no_output", 128'(b.Output_valid), 128'(0));
      @(negedge clk);
    end
    run_block(K2, PT2, 1'b1, CT2, "rmid_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
